// File: rtl/shm_seq.sv
// shm_seq: sequenced shift matrix.
// Shifts or rotates the double word {AR,ARX} left by a run-time count, moving at most STEP bits
// per clock. ARX-select and AR half-swap complete in a single cycle. Results are registered
// together with the derived index field, indexed flag and SH parity.
// Bit 0 of a word is its MSB in the machine's numbering; vectors here are [WORD-1:0], so
// machine bit k lives at vector index WORD-1-k.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               operation request, sampled only when idle
//   CRAM_SH             mode: 0 shift, 1 rotate, 2 ARX select, 3 AR half-swap
//   count               shift distance
//   EDP_AR, EDP_ARX     operand high / low words
//   busy, done          sequencer status; done is a one-cycle result-valid pulse
//   SHM_SH, SHM_SHX     result high / low words
//   SHM_XR, indexed     index field of SH and its OR-reduce
//   SHparityOdd         XOR-reduce of SH
module shm_seq #(
   parameter int unsigned WORD  = 36,
   parameter int unsigned STEP  = 9,
   parameter int unsigned CNTW  = 8,
   parameter int unsigned XRPOS = 14,
   parameter int unsigned XRW   = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      CRAM_SH,
   input  logic [CNTW-1:0] count,
   input  logic [WORD-1:0] EDP_AR,
   input  logic [WORD-1:0] EDP_ARX,
   output logic            busy,
   output logic            done,
   output logic [WORD-1:0] SHM_SH,
   output logic [WORD-1:0] SHM_SHX,
   output logic [XRW-1:0]  SHM_XR,
   output logic            indexed,
   output logic            SHparityOdd
);

   localparam logic [1:0] ModeShift = 2'd0;
   localparam logic [1:0] ModeRot   = 2'd1;
   localparam logic [1:0] ModeArx   = 2'd2;
   localparam logic [1:0] ModeSwap  = 2'd3;

   localparam logic [CNTW-1:0] DwC   = CNTW'(2 * WORD);
   localparam logic [CNTW-1:0] StepC = CNTW'(STEP);
   localparam int unsigned     XrHi  = WORD - 1 - XRPOS;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [2*WORD-1:0] acc_q, acc_d;
   logic [CNTW-1:0]   rem_q, rem_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [WORD-1:0]   sh_q, sh_d;
   logic [WORD-1:0]   shx_q, shx_d;
   logic [XRW-1:0]    xr_q, xr_d;
   logic              idx_q, idx_d;
   logic              par_q, par_d;

   logic              wr;
   logic [WORD-1:0]   sh_new, shx_new;
   logic [CNTW-1:0]   step, rem_next;
   logic [2*WORD-1:0] acc_next;

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      wr       = 1'b0;
      sh_new   = '0;
      shx_new  = '0;
      step     = '0;
      rem_next = '0;
      acc_next = '0;

      case (state_q)
         StIdle: begin
            if (start) begin
               mode_d = CRAM_SH;
               acc_d  = {EDP_AR, EDP_ARX};
               rem_d  = count;
               if (CRAM_SH == ModeArx || CRAM_SH == ModeSwap || count == '0) begin
                  wr      = 1'b1;
                  shx_new = EDP_ARX;
                  state_d = StDone;
                  case (CRAM_SH)
                     ModeArx:  sh_new = EDP_ARX;
                     ModeSwap: sh_new = {EDP_AR[WORD/2-1:0], EDP_AR[WORD-1:WORD/2]};
                     default:  sh_new = EDP_AR;
                  endcase
               end else begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            step = (rem_q < StepC) ? rem_q : StepC;
            if (mode_q == ModeShift && rem_q >= DwC) begin
               // Everything would be shifted out anyway: finish in one edge.
               acc_next = '0;
               rem_next = '0;
            end else if (mode_q == ModeRot) begin
               acc_next = (acc_q << step) | (acc_q >> (DwC - step));
               rem_next = rem_q - step;
            end else begin
               acc_next = acc_q << step;
               rem_next = rem_q - step;
            end
            acc_d = acc_next;
            rem_d = rem_next;
            if (rem_next == '0) begin
               wr      = 1'b1;
               sh_new  = acc_next[2*WORD-1:WORD];
               shx_new = acc_next[WORD-1:0];
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      sh_d  = sh_q;
      shx_d = shx_q;
      xr_d  = xr_q;
      idx_d = idx_q;
      par_d = par_q;
      if (wr) begin
         sh_d  = sh_new;
         shx_d = shx_new;
         xr_d  = sh_new[XrHi -: XRW];
         idx_d = |sh_new[XrHi -: XRW];
         par_d = ^sh_new;
      end

      busy_d = (state_d != StIdle);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         mode_q  <= ModeShift;
         acc_q   <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sh_q    <= '0;
         shx_q   <= '0;
         xr_q    <= '0;
         idx_q   <= 1'b0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sh_q    <= sh_d;
         shx_q   <= shx_d;
         xr_q    <= xr_d;
         idx_q   <= idx_d;
         par_q   <= par_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign SHM_SH      = sh_q;
   assign SHM_SHX     = shx_q;
   assign SHM_XR      = xr_q;
   assign indexed     = idx_q;
   assign SHparityOdd = par_q;

endmodule

// File: tb/tb_shm_seq.sv
// Self-checking bench for shm_seq with default parameters (36-bit words, 9-bit step).
module tb_shm_seq;

   localparam int W = 36;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [1:0]    CRAM_SH;
   logic [7:0]    count;
   logic [W-1:0]  EDP_AR, EDP_ARX;
   logic          busy, done;
   logic [W-1:0]  SHM_SH, SHM_SHX;
   logic [3:0]    SHM_XR;
   logic          indexed, SHparityOdd;

   int n_chk  = 0;
   int n_pass = 0;

   shm_seq dut (
      .clk(clk), .reset(reset), .start(start), .CRAM_SH(CRAM_SH), .count(count),
      .EDP_AR(EDP_AR), .EDP_ARX(EDP_ARX), .busy(busy), .done(done),
      .SHM_SH(SHM_SH), .SHM_SHX(SHM_SHX), .SHM_XR(SHM_XR), .indexed(indexed),
      .SHparityOdd(SHparityOdd)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] rnd_word();
      return W'({$urandom(), $urandom()});
   endfunction

   // Reference: final result of the whole operation, computed in one step.
   function automatic logic [2*W-1:0] model_res(input logic [1:0] m, input int c,
                                                input logic [W-1:0] ar, input logic [W-1:0] arx);
      logic [2*W-1:0] v;
      int n;
      v = {ar, arx};
      case (m)
         2'd2: return {arx, arx};
         2'd3: return {ar[W/2-1:0], ar[W-1:W/2], arx};
         2'd0: return (c >= 2*W) ? '0 : (v << c);
         default: begin
            n = c % (2*W);
            if (n == 0) return v;
            return (v << n) | (v >> (2*W - n));
         end
      endcase
   endfunction

   function automatic int model_lat(input logic [1:0] m, input int c);
      if (m >= 2'd2 || c == 0) return 1;
      if (m == 2'd0 && c >= 2*W) return 2;
      return 1 + (c + 8) / 9;
   endfunction

   // Index field: machine bits 14..17 (bit 0 = MSB).
   function automatic logic [3:0] model_xr(input logic [W-1:0] sh);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[3-i] = sh[W-1-(14+i)];
      return r;
   endfunction

   function automatic logic model_par(input logic [W-1:0] sh);
      int ones = 0;
      for (int i = 0; i < W; i++) if (sh[i]) ones++;
      return (ones % 2) == 1;
   endfunction

   // Starts one operation and waits (bounded) for done. Returns the cycle on which done showed.
   task automatic do_op(input logic [1:0] m, input logic [7:0] c, input logic [W-1:0] ar,
                        input logic [W-1:0] arx, input bit spam, output int lat,
                        output bit busy_ok);
      start = 1'b1; CRAM_SH = m; count = c; EDP_AR = ar; EDP_ARX = arx;
      tick();
      start = 1'b0;
      lat = 1;
      busy_ok = 1'b1;
      while (done !== 1'b1 && lat < 300) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         EDP_AR = rnd_word(); EDP_ARX = rnd_word();
         CRAM_SH = 2'($urandom()); count = 8'($urandom());
         if (spam) start = 1'($urandom());
         tick();
         lat++;
      end
      start = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; CRAM_SH = 2'd2; count = 8'd0;
      EDP_AR = rnd_word(); EDP_ARX = rnd_word();
      repeat (3) tick();
      n_chk++; if ({busy, done} !== 2'b00) $display("FAIL reset_status got %b want 00", {busy, done}); else n_pass++;
      n_chk++; if ({SHM_SH, SHM_SHX, SHM_XR, indexed, SHparityOdd} !== '0)
         $display("FAIL reset_outputs got %h/%h/%h/%b/%b want zeros", SHM_SH, SHM_SHX, SHM_XR, indexed, SHparityOdd);
      else n_pass++;
      reset = 1'b0; start = 1'b0;
      tick();
      n_chk++; if ({busy, done} !== 2'b00) $display("FAIL reset_idle got %b want 00", {busy, done}); else n_pass++;
   endtask

   task automatic test_shift1();
      int lat; bit bok;
      do_op(2'd0, 8'd1, 36'o000000000001, 36'o400000000000, 1'b0, lat, bok);
      n_chk++; if (lat !== 2) $display("FAIL shift1_lat got %0d want 2", lat); else n_pass++;
      n_chk++; if (SHM_SH !== 36'o3) $display("FAIL shift1_sh got %o want 3", SHM_SH); else n_pass++;
      n_chk++; if (SHM_SHX !== 36'o0) $display("FAIL shift1_shx got %o want 0", SHM_SHX); else n_pass++;
      n_chk++; if (SHparityOdd !== 1'b0) $display("FAIL shift1_par got %b want 0", SHparityOdd); else n_pass++;
      tick();
      n_chk++; if ({busy, done} !== 2'b00) $display("FAIL shift1_after got %b want 00", {busy, done}); else n_pass++;
   endtask

   task automatic test_rotate72();
      int lat; bit bok;
      do_op(2'd1, 8'd72, 36'o123456701234, 36'o555555555555, 1'b1, lat, bok);
      n_chk++; if (lat !== 9) $display("FAIL rot72_lat got %0d want 9", lat); else n_pass++;
      n_chk++; if (bok !== 1'b1) $display("FAIL rot72_busy got %b want 1", bok); else n_pass++;
      n_chk++; if ({SHM_SH, SHM_SHX} !== {36'o123456701234, 36'o555555555555})
         $display("FAIL rot72_result got %o/%o want 123456701234/555555555555", SHM_SH, SHM_SHX);
      else n_pass++;
      tick();
      n_chk++; if ({busy, done} !== 2'b00) $display("FAIL rot72_after got %b want 00", {busy, done}); else n_pass++;
   endtask

   task automatic test_swap();
      int lat; bit bok;
      logic [W-1:0] arx;
      arx = rnd_word();
      do_op(2'd3, 8'($urandom()), 36'o123456654321, arx, 1'b0, lat, bok);
      n_chk++; if (lat !== 1) $display("FAIL swap_lat got %0d want 1", lat); else n_pass++;
      n_chk++; if (SHM_SH !== 36'o654321123456) $display("FAIL swap_sh got %o want 654321123456", SHM_SH); else n_pass++;
      n_chk++; if (SHM_SHX !== arx) $display("FAIL swap_shx got %o want %o", SHM_SHX, arx); else n_pass++;
      n_chk++; if ({SHM_XR, indexed, SHparityOdd} !== 6'b0001_1_0)
         $display("FAIL swap_xr got %b/%b/%b want 0001/1/0", SHM_XR, indexed, SHparityOdd);
      else n_pass++;
      tick();
   endtask

   task automatic test_sat_then_arx();
      int lat; bit bok;
      do_op(2'd0, 8'd200, rnd_word(), rnd_word(), 1'b0, lat, bok);
      n_chk++; if (lat !== 2) $display("FAIL sat_lat got %0d want 2", lat); else n_pass++;
      n_chk++; if ({SHM_SH, SHM_SHX, indexed} !== '0)
         $display("FAIL sat_result got %o/%o/%b want 0/0/0", SHM_SH, SHM_SHX, indexed);
      else n_pass++;
      tick();
      do_op(2'd2, 8'($urandom()), rnd_word(), 36'o1, 1'b0, lat, bok);
      n_chk++; if (lat !== 1) $display("FAIL b2b_arx_lat got %0d want 1", lat); else n_pass++;
      n_chk++; if ({SHM_SH, SHM_SHX, SHparityOdd} !== {36'o1, 36'o1, 1'b1})
         $display("FAIL b2b_arx_result got %o/%o/%b want 1/1/1", SHM_SH, SHM_SHX, SHparityOdd);
      else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid_run();
      int lat; bit bok; bit seen;
      logic [W-1:0] ar, arx;
      logic [2*W-1:0] exp;
      start = 1'b1; CRAM_SH = 2'd0; count = 8'd40; EDP_AR = rnd_word(); EDP_ARX = rnd_word();
      tick();
      start = 1'b0;
      tick(); tick();
      n_chk++; if ({busy, done} !== 2'b10) $display("FAIL midrun_status got %b want 10", {busy, done}); else n_pass++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_chk++; if ({busy, done} !== 2'b00) $display("FAIL midrun_reset_status got %b want 00", {busy, done}); else n_pass++;
      n_chk++; if ({SHM_SH, SHM_SHX, SHM_XR, indexed, SHparityOdd} !== '0)
         $display("FAIL midrun_reset_outputs got %o/%o/%b want zeros", SHM_SH, SHM_SHX, SHM_XR);
      else n_pass++;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
         tick();
      end
      n_chk++; if (seen !== 1'b0) $display("FAIL midrun_no_done got %b want 0", seen); else n_pass++;
      ar = rnd_word(); arx = rnd_word();
      exp = model_res(2'd0, 40, ar, arx);
      do_op(2'd0, 8'd40, ar, arx, 1'b0, lat, bok);
      n_chk++; if (lat !== 6) $display("FAIL midrun_next_lat got %0d want 6", lat); else n_pass++;
      n_chk++; if ({SHM_SH, SHM_SHX} !== exp)
         $display("FAIL midrun_next_result got %o/%o want %o/%o", SHM_SH, SHM_SHX, exp[2*W-1:W], exp[W-1:0]);
      else n_pass++;
      tick();
   endtask

   task automatic test_random();
      int lat, c, elat; bit bok;
      logic [1:0] m;
      logic [W-1:0] ar, arx, sh;
      logic [2*W-1:0] exp;
      for (int k = 0; k < 40; k++) begin
         m = 2'($urandom());
         case ($urandom() % 4)
            0: c = 0;
            1: c = $urandom_range(1, 20);
            2: c = $urandom_range(21, 71);
            default: c = $urandom_range(72, 255);
         endcase
         ar = rnd_word(); arx = rnd_word();
         exp = model_res(m, c, ar, arx);
         elat = model_lat(m, c);
         sh = exp[2*W-1:W];
         do_op(m, 8'(c), ar, arx, 1'($urandom()), lat, bok);
         n_chk++; if (lat !== elat) $display("FAIL rnd%0d_lat m=%0d c=%0d got %0d want %0d", k, m, c, lat, elat); else n_pass++;
         n_chk++; if (bok !== 1'b1) $display("FAIL rnd%0d_busy got %b want 1", k, bok); else n_pass++;
         n_chk++; if ({SHM_SH, SHM_SHX} !== exp)
            $display("FAIL rnd%0d_result m=%0d c=%0d got %o/%o want %o/%o", k, m, c, SHM_SH, SHM_SHX, sh, exp[W-1:0]);
         else n_pass++;
         n_chk++; if ({SHM_XR, indexed, SHparityOdd} !== {model_xr(sh), |model_xr(sh), model_par(sh)})
            $display("FAIL rnd%0d_derived got %b/%b/%b want %b/%b/%b", k, SHM_XR, indexed, SHparityOdd,
                     model_xr(sh), |model_xr(sh), model_par(sh));
         else n_pass++;
         tick();
         n_chk++; if ({busy, done, SHM_SH} !== {2'b00, sh})
            $display("FAIL rnd%0d_after got %b%b/%o want 00/%o", k, busy, done, SHM_SH, sh);
         else n_pass++;
         repeat ($urandom() % 3) tick();
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; CRAM_SH = 2'd0; count = 8'd0; EDP_AR = '0; EDP_ARX = '0;
      test_reset();
      test_shift1();
      test_rotate72();
      test_swap();
      test_sat_then_arx();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/shm_seq.md
Name: shm_seq

Overview:
- Parametrised, sequenced successor to the shift-matrix block.
- Shifts or rotates the double word {AR,ARX} left by a run-time count. Moves at most STEP bits per clock instead of using a full barrel.
- Also offers single-cycle ARX-select and AR half-swap modes.
- Registers SH/SHX and derives the XR index field, indexed flag and SH parity. Sits between EDP AR/ARX and the SH bus, driven by CRAM_SH and a start/done handshake from the microsequencer.

Parameters:
- WORD, 36, data word width; bits numbered [0:WORD-1], bit 0 = MSB.
- STEP, 9, maximum shift distance per RUN cycle (1..2*WORD).
- CNTW, 8, width of shift count.
- XRPOS, 14, SH bit number of the index field MSB.
- XRW, 4, index field width (XRPOS+XRW <= WORD).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- CRAM_SH  in  2  mode: 0 SHIFT (logical, zero fill), 1 ROTATE, 2 ARX, 3 SWAP.
- count  in  CNTW  shift distance (unsigned).
- EDP_AR  in  WORD  high operand word.
- EDP_ARX  in  WORD  low operand word.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle result-valid pulse.
- SHM_SH  out  WORD  result high word.
- SHM_SHX  out  WORD  result low word.
- SHM_XR  out  XRW  SHM_SH[XRPOS:XRPOS+XRW-1].
- indexed  out  1  |SHM_XR.
- SHparityOdd  out  1  XOR-reduce of SHM_SH.

Behaviour:
- Reset (synchronous, active-high) forces the following, regardless of state, including mid-RUN:
  - state = IDLE; busy = 0, done = 0.
  - SHM_SH, SHM_SHX, SHM_XR, indexed, SHparityOdd = 0.
  - The internal accumulator and remaining count are cleared.
  - An in-flight operation is abandoned; no done pulse is ever produced for it.
- States are IDLE, RUN and DONE; busy = (state != IDLE).
- IDLE, when start = 1 on edge E0:
  - CRAM_SH and count are latched; acc <= {EDP_AR, EDP_ARX}; rem <= count.
  - Mode ARX, or mode SWAP, or count = 0: result registers are written at E0 and the next state is DONE.
    - ARX: SH = EDP_ARX, SHX = EDP_ARX.
    - SWAP: SH = {AR right half, AR left half}, SHX = EDP_ARX.
    - SHIFT/ROTATE with count 0: SH = EDP_AR, SHX = EDP_ARX.
  - Otherwise the next state is RUN.
- RUN, each edge:
  - s = min(rem, STEP).
  - SHIFT: acc <= acc << s, zero fill from the right.
  - ROTATE: acc <= acc rotated left s; bits leaving bit 0 of AR enter bit WORD-1 of ARX.
  - rem <= rem - s.
  - SHIFT saturation: if rem >= 2*WORD in SHIFT mode, acc <= 0 and rem <= 0 in that single edge.
  - When the post-update rem = 0, the same edge writes SH/SHX from the new acc and moves to DONE.
  - ROTATE does not reduce the count modulo 2*WORD; it iterates the full count.
- DONE:
  - done = 1 for exactly this one cycle; next state is IDLE.
  - start in DONE or RUN is ignored (not queued).
- Latency (start edge to done visible):
  - 1 cycle for ARX, SWAP or count 0.
  - 1 + ceil(count/STEP) cycles for SHIFT/ROTATE.
  - 2 cycles for saturated SHIFT.
  - Back-to-back operations: a new start is accepted the cycle after done.
- Output registers, SHM_XR, indexed and SHparityOdd:
  - They change only on the edge entering DONE, or on reset.
  - They hold between operations.
  - SHM_XR, indexed and SHparityOdd are registered alongside SH, so they are consistent with SH in the done cycle.
- EDP_AR/ARX/count/CRAM_SH are don't-care outside the start edge.

Test Plan:
- Reset then idle: outputs all 0, busy 0; start with reset high is ignored.
- SHIFT, count=1, AR=0o000000000001, ARX=0o400000000000 -> done 2 cycles after start, SH=0o000000000003, SHX=0, SHparityOdd=0.
- ROTATE, count=72, STEP=9, AR=0o123456701234, ARX=0o555555555555 -> busy 9 cycles, done at cycle 9, SH/SHX unchanged from inputs; start pulses during busy are ignored.
- SWAP, AR=0o123456654321 -> done at cycle 1, SH=0o654321123456, SHM_XR=4'b0001, indexed=1, SHparityOdd=0.
- SHIFT, count=200 (saturation) -> done at cycle 2, SH=SHX=0, indexed=0. Then ARX mode, ARX=0o000000000001, started the cycle after done -> SH=1, SHparityOdd=1, done at cycle 1.
- SHIFT count=40 -> assert reset at the third RUN cycle -> next cycle busy=0, outputs 0, no done ever; a subsequent normal start completes correctly.
